bitmanip_rot_arbiter: RTL

BITMANIP_ROT_ARBITER -- requirements
Module: bitmanip_rot_arbiter

---
 rtl/bitmanip_rot_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/bitmanip_rot_arbiter.sv
// Two-requester round-robin arbiter that feeds one shared rotate unit.
// The one-entry result register is held until the consumer takes it.
module bitmanip_rot_arbiter #(
   parameter int SIZE       = 16,
   parameter int SHAMT_SIZE = $clog2(SIZE)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [SIZE-1:0]       req0_data_i,
   input  logic [SHAMT_SIZE-1:0] req0_shamt_i,
   input  logic                  req0_dir_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [SIZE-1:0]       req1_data_i,
   input  logic [SHAMT_SIZE-1:0] req1_shamt_i,
   input  logic                  req1_dir_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [SIZE-1:0]       resp_data_o,
   output logic                  resp_id_o
);

   // state | meaning
   // IDLE  | no result held, requesters may be granted
   // RESP  | result held, waiting for resp_ready_i
   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [SIZE-1:0]   resp_data_q, resp_data_d;
   logic              resp_id_q, resp_id_d;

   logic                  grant_valid;
   logic                  grant_idx;
   logic [SIZE-1:0]       sel_data;
   logic [SHAMT_SIZE-1:0] sel_shamt;
   logic                  sel_dir;
   logic [SHAMT_SIZE-1:0] rol_amt;
   logic [SHAMT_SIZE:0]   comp_amt;
   logic [SIZE-1:0]       rot_result;

   always_comb begin
      grant_valid = (state_q == IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
      grant_idx   = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         grant_idx = ~last_grant_q;
      end else if (req1_valid_i) begin
         grant_idx = 1'b1;
      end
   end

   assign req0_ready_o = grant_valid && !grant_idx;
   assign req1_ready_o = grant_valid && grant_idx;

   // Single shared datapath: only the granted operand reaches the rotator.
   always_comb begin
      sel_data  = grant_idx ? req1_data_i  : req0_data_i;
      sel_shamt = grant_idx ? req1_shamt_i : req0_shamt_i;
      sel_dir   = grant_idx ? req1_dir_i   : req0_dir_i;
   end

   // Right rotate is a left rotate by the two's complement of the amount,
   // which wraps modulo SIZE because SIZE is a power of two.
   always_comb begin
      rol_amt    = sel_dir ? (SHAMT_SIZE'(0) - sel_shamt) : sel_shamt;
      comp_amt   = (SHAMT_SIZE+1)'(SIZE) - {1'b0, rol_amt};
      rot_result = sel_data;
      if (rol_amt != '0) begin
         rot_result = (sel_data << rol_amt) | (sel_data >> comp_amt);
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = RESP;
               last_grant_d = grant_idx;
               resp_data_d  = rot_result;
               resp_id_d    = grant_idx;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         resp_data_q  <= '0;
         resp_id_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
      end
   end

   assign resp_valid_o = (state_q == RESP);
   assign resp_data_o  = resp_data_q;
   assign resp_id_o    = resp_id_q;

endmodule
